// File: rtl/bp_be_mmu_cmd_sched.sv
// In-order command queue: one-cycle enqueue-to-head latency, no bypass.
// Backpressure: the producer holds its command while full; clr_i empties the queue in one edge.
module bp_be_mmu_cmd_sched_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clr_i,
  input  logic                     enq_vld_i,
  input  logic [width_p-1:0]       enq_dat_i,
  input  logic                     deq_rdy_i,
  output logic [width_p-1:0]       deq_dat_o,
  output logic [$clog2(els_p):0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [width_p-1:0]  mem_q [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w_lp-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (enq_vld_i) begin
      mem_q[wr_ptr_q] <= enq_dat_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by overflow.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq_vld_i) wr_ptr_q <= wr_ptr_q + ptr_w_lp'(1);
      if (deq_rdy_i) rd_ptr_q <= rd_ptr_q + ptr_w_lp'(1);
      count_q <= count_q + cnt_w_lp'(enq_vld_i) - cnt_w_lp'(deq_rdy_i);
    end
  end

  assign deq_dat_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// Schedules mem-pipe commands onto the MMU port, one in flight, replaying misses after the fill.
// Issue is earliest one cycle after enqueue; cmd_ready_o drops when the queue is full.
module bp_be_mmu_cmd_sched #(
  parameter  int vaddr_width_p = 39,
  parameter  int queue_els_p   = 4,
  localparam int cmd_width_lp  = 4 + 64 + vaddr_width_p
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [cmd_width_lp-1:0] cmd_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_o,
  output logic [cmd_width_lp-1:0] mmu_cmd_o,
  output logic                    mmu_cmd_v_o,
  input  logic                    mmu_cmd_ready_i,
  input  logic                    mmu_resp_v_i,
  input  logic                    cache_miss_i,
  input  logic                    miss_done_i,
  input  logic                    flush_i,
  output logic                    result_v_o,
  output logic                    busy_o,
  output logic [15:0]             miss_cnt_o
);

  localparam int cnt_w_lp = $clog2(queue_els_p) + 1;

  typedef struct packed {
    logic [3:0]               mem_op;
    logic [63:0]              data;
    logic [vaddr_width_p-1:0] vaddr;
  } cmd_t;

  typedef enum logic [2:0] {
    e_idle,
    e_wait,
    e_miss,
    e_replay,
    e_drain
  } state_e;

  state_e        state_q, state_d;
  cmd_t          inf_q, head;
  logic [15:0]   miss_cnt_q;
  logic [cnt_w_lp-1:0] count;
  logic          empty, enq, deq, issue, miss_inc;

  bp_be_mmu_cmd_sched_fifo #(
    .width_p (cmd_width_lp),
    .els_p   (queue_els_p)
  ) cmd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (flush_i),
    .enq_vld_i (enq),
    .enq_dat_i (cmd_i),
    .deq_rdy_i (deq),
    .deq_dat_o (head),
    .count_o   (count)
  );

  assign empty       = (count == '0);
  assign cmd_ready_o = reset_n_i & (count != cnt_w_lp'(queue_els_p));
  assign enq         = cmd_v_i & cmd_ready_o & ~flush_i;

  // Flush masks the request so no handshake can race the kill.
  assign mmu_cmd_v_o = reset_n_i & ~flush_i
                     & (((state_q == e_idle) & ~empty) | (state_q == e_replay));
  assign mmu_cmd_o   = (state_q == e_replay) ? inf_q : head;
  assign issue       = mmu_cmd_v_o & mmu_cmd_ready_i;
  assign deq         = issue & (state_q == e_idle);

  assign result_v_o  = reset_n_i & (state_q == e_wait) & mmu_resp_v_i
                     & ~cache_miss_i & ~flush_i;
  assign miss_inc    = (state_q == e_wait) & mmu_resp_v_i & cache_miss_i & ~flush_i;
  assign busy_o      = ~empty | (state_q != e_idle);
  assign miss_cnt_o  = miss_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle:   if (issue) state_d = e_wait;
      e_wait: begin
        if (mmu_resp_v_i) begin
          state_d = (cache_miss_i & ~flush_i) ? e_miss : e_idle;
        end else if (flush_i) begin
          state_d = e_drain;
        end
      end
      e_miss: begin
        if (flush_i)          state_d = e_idle;
        else if (miss_done_i) state_d = e_replay;
      end
      e_replay: begin
        if (flush_i)    state_d = e_idle;
        else if (issue) state_d = e_wait;
      end
      // The outstanding response is swallowed whether or not another flush arrives.
      e_drain:  if (mmu_resp_v_i) state_d = e_idle;
      default:  state_d = e_idle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= e_idle;
      inf_q      <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (deq)      inf_q      <= head;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_be_mmu_cmd_sched.sv
// Bench for bp_be_mmu_cmd_sched: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_bp_be_mmu_cmd_sched;

  localparam int VW = 39;
  localparam int QD = 4;
  localparam int CW = 4 + 64 + VW;

  logic          clk_i = 1'b0;
  logic          reset_n_i;
  logic [CW-1:0] cmd_i;
  logic          cmd_v_i;
  logic          cmd_ready_o;
  logic [CW-1:0] mmu_cmd_o;
  logic          mmu_cmd_v_o;
  logic          mmu_cmd_ready_i;
  logic          mmu_resp_v_i;
  logic          cache_miss_i;
  logic          miss_done_i;
  logic          flush_i;
  logic          result_v_o;
  logic          busy_o;
  logic [15:0]   miss_cnt_o;

  bp_be_mmu_cmd_sched #(.vaddr_width_p(VW), .queue_els_p(QD)) dut (
    .clk_i           (clk_i),
    .reset_n_i       (reset_n_i),
    .cmd_i           (cmd_i),
    .cmd_v_i         (cmd_v_i),
    .cmd_ready_o     (cmd_ready_o),
    .mmu_cmd_o       (mmu_cmd_o),
    .mmu_cmd_v_o     (mmu_cmd_v_o),
    .mmu_cmd_ready_i (mmu_cmd_ready_i),
    .mmu_resp_v_i    (mmu_resp_v_i),
    .cache_miss_i    (cache_miss_i),
    .miss_done_i     (miss_done_i),
    .flush_i         (flush_i),
    .result_v_o      (result_v_o),
    .busy_o          (busy_o),
    .miss_cnt_o      (miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a plain queue of pending commands plus what the one outstanding command is doing.
  typedef enum {M_FREE, M_OUT, M_FILL, M_RETRY, M_DROP} mode_e;
  logic [CW-1:0] mq[$];
  logic [CW-1:0] minf;
  mode_e         mmode;
  logic [15:0]   mmiss;
  bit            chk_en = 0;

  bit            acc;
  bit            iss_now;
  bit            auto_resp = 0;
  logic [VW-1:0] issued_q[$];

  typedef struct {
    bit            cmd_v;
    logic [VW-1:0] va;
    bit            resp;
    bit            e_rdy;
    bit            e_mv;
    logic [VW-1:0] e_va;
    bit            e_res;
    bit            e_busy;
  } vec_t;
  vec_t tbl[11];

  function automatic vec_t mkv(bit cv, logic [VW-1:0] va, bit rsp, bit rdy, bit mv,
                               logic [VW-1:0] eva, bit res, bit busy);
    vec_t v;
    v.cmd_v = cv; v.va = va; v.resp = rsp; v.e_rdy = rdy;
    v.e_mv = mv; v.e_va = eva; v.e_res = res; v.e_busy = busy;
    return v;
  endfunction

  function automatic logic [CW-1:0] mk_cmd(logic [3:0] op, logic [63:0] d, logic [VW-1:0] va);
    return {op, d, va};
  endfunction

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, required %h", nm, $time, act, exp);
    end
  endtask

  function automatic bit m_mv();
    return reset_n_i && !flush_i &&
           ((mmode == M_FREE && mq.size() != 0) || mmode == M_RETRY);
  endfunction

  task automatic model_check();
    bit e_rdy, e_res, e_busy;
    e_rdy  = reset_n_i && (mq.size() != QD);
    e_res  = reset_n_i && mmode == M_OUT && mmu_resp_v_i && !cache_miss_i && !flush_i;
    e_busy = (mq.size() != 0) || (mmode != M_FREE);
    chk("cmd_ready", CW'(cmd_ready_o), CW'(e_rdy));
    chk("mmu_cmd_v", CW'(mmu_cmd_v_o), CW'(m_mv()));
    chk("result_v",  CW'(result_v_o),  CW'(e_res));
    chk("busy",      CW'(busy_o),      CW'(e_busy));
    chk("miss_cnt",  CW'(miss_cnt_o),  CW'(mmiss));
    if (m_mv()) chk("mmu_cmd", mmu_cmd_o, (mmode == M_RETRY) ? minf : mq[0]);
  endtask

  task automatic model_update();
    bit hs, enq;
    if (!reset_n_i) begin
      mq.delete();
      mmode = M_FREE;
      mmiss = '0;
      minf  = '0;
      return;
    end
    hs  = m_mv() && mmu_cmd_ready_i;
    enq = cmd_v_i && (mq.size() != QD) && !flush_i;
    if (flush_i) mq.delete();
    else begin
      if (hs && mmode == M_FREE) minf = mq.pop_front();
      if (enq) mq.push_back(cmd_i);
    end
    case (mmode)
      M_FREE:  if (hs) mmode = M_OUT;
      M_OUT: begin
        if (mmu_resp_v_i) begin
          if (cache_miss_i && !flush_i) begin
            mmiss = mmiss + 16'd1;
            mmode = M_FILL;
          end else mmode = M_FREE;
        end else if (flush_i) mmode = M_DROP;
      end
      M_FILL:  if (flush_i) mmode = M_FREE; else if (miss_done_i) mmode = M_RETRY;
      M_RETRY: if (flush_i) mmode = M_FREE; else if (hs) mmode = M_OUT;
      M_DROP:  if (mmu_resp_v_i) mmode = M_FREE;
      default: mmode = M_FREE;
    endcase
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk_i);
    if (chk_en) model_check();
    acc     = cmd_v_i && cmd_ready_o;
    iss_now = mmu_cmd_v_o && mmu_cmd_ready_i;
    if (iss_now) issued_q.push_back(mmu_cmd_o[VW-1:0]);
    @(posedge clk_i);
    model_update();
    #1;
    if (auto_resp) begin
      mmu_resp_v_i = iss_now;
      cache_miss_i = 1'b0;
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    cmd_v_i = 0; cmd_i = '0; mmu_cmd_ready_i = 0; mmu_resp_v_i = 0;
    cache_miss_i = 0; miss_done_i = 0; flush_i = 0;
  endtask

  task automatic rst();
    idle_inputs();
    reset_n_i = 0;
    step();
    reset_n_i = 1;
  endtask

  task automatic send(input logic [CW-1:0] c, input int budget);
    int b = 0;
    cmd_v_i = 1; cmd_i = c;
    do begin step(); b++; end while (!acc && b < budget);
    cmd_v_i = 0;
    chk("send_accept", CW'(acc), CW'(1'b1));
  endtask

  task automatic wait_idle(input int budget);
    int b = 0;
    while ((mq.size() != 0 || mmode != M_FREE) && b < budget) begin
      step(); b++;
    end
    chk("reach_idle", CW'(mq.size() == 0 && mmode == M_FREE), CW'(1'b1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset_n_i = 0;
    step();
    chk_en = 1;

    // Reset state, with requests pending to show the outputs are gated.
    cmd_v_i = 1; mmu_cmd_ready_i = 1; mmu_resp_v_i = 1;
    settle();
    chk("rst_cmd_ready", CW'(cmd_ready_o), CW'(1'b0));
    chk("rst_mmu_v",     CW'(mmu_cmd_v_o), CW'(1'b0));
    chk("rst_result",    CW'(result_v_o),  CW'(1'b0));
    chk("rst_busy",      CW'(busy_o),      CW'(1'b0));
    chk("rst_miss_cnt",  CW'(miss_cnt_o),  CW'(16'd0));
    step();
    reset_n_i = 1;
    idle_inputs();

    // Three loads, response two cycles after each issue.
    tbl[0]  = mkv(1, 39'h100, 0, 1, 0, 39'h0,   0, 0);
    tbl[1]  = mkv(1, 39'h108, 0, 1, 1, 39'h100, 0, 1);
    tbl[2]  = mkv(1, 39'h110, 0, 1, 0, 39'h0,   0, 1);
    tbl[3]  = mkv(0, 39'h0,   1, 1, 0, 39'h0,   1, 1);
    tbl[4]  = mkv(0, 39'h0,   0, 1, 1, 39'h108, 0, 1);
    tbl[5]  = mkv(0, 39'h0,   0, 1, 0, 39'h0,   0, 1);
    tbl[6]  = mkv(0, 39'h0,   1, 1, 0, 39'h0,   1, 1);
    tbl[7]  = mkv(0, 39'h0,   0, 1, 1, 39'h110, 0, 1);
    tbl[8]  = mkv(0, 39'h0,   0, 1, 0, 39'h0,   0, 1);
    tbl[9]  = mkv(0, 39'h0,   1, 1, 0, 39'h0,   1, 1);
    tbl[10] = mkv(0, 39'h0,   0, 1, 0, 39'h0,   0, 0);
    for (int i = 0; i < 11; i++) begin
      mmu_cmd_ready_i = 1;
      cmd_v_i = tbl[i].cmd_v;
      cmd_i = mk_cmd(4'h1, 64'h0, tbl[i].va);
      mmu_resp_v_i = tbl[i].resp;
      settle();
      chk($sformatf("vec%0d_rdy", i),  CW'(cmd_ready_o), CW'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_mv", i),   CW'(mmu_cmd_v_o), CW'(tbl[i].e_mv));
      chk($sformatf("vec%0d_res", i),  CW'(result_v_o),  CW'(tbl[i].e_res));
      chk($sformatf("vec%0d_busy", i), CW'(busy_o),      CW'(tbl[i].e_busy));
      if (tbl[i].e_mv) chk($sformatf("vec%0d_va", i), CW'(mmu_cmd_o[VW-1:0]), CW'(tbl[i].e_va));
      step();
    end

    // Fill the queue with the MMU stalled, then release it.
    rst();
    issued_q.delete();
    auto_resp = 1;
    for (int i = 0; i < 4; i++) send(mk_cmd(4'h2, 64'(i), VW'(39'h300 + 39'(8 * i))), 8);
    cmd_v_i = 1; cmd_i = mk_cmd(4'h2, 64'd4, 39'h320);
    settle();
    chk("full_cmd_ready", CW'(cmd_ready_o), CW'(1'b0));
    step(); step();
    mmu_cmd_ready_i = 1;
    send(mk_cmd(4'h2, 64'd4, 39'h320), 10);
    wait_idle(40);
    auto_resp = 0;
    mmu_resp_v_i = 0;
    chk("order_count", CW'(issued_q.size()), CW'(5));
    for (int i = 0; i < 5; i++)
      chk($sformatf("order%0d", i), CW'(issued_q[i]), CW'(39'h300 + 39'(8 * i)));

    // Miss, replay, miss again, replay, hit.
    rst();
    mmu_cmd_ready_i = 1;
    send(mk_cmd(4'h1, 64'h0, 39'h200), 4);
    settle();
    chk("miss_issue_v",  CW'(mmu_cmd_v_o), CW'(1'b1));
    chk("miss_issue_va", CW'(mmu_cmd_o[VW-1:0]), CW'(39'h200));
    step();
    mmu_resp_v_i = 1; cache_miss_i = 1;
    settle();
    chk("miss_no_result", CW'(result_v_o), CW'(1'b0));
    step();
    mmu_resp_v_i = 0; cache_miss_i = 0;
    repeat (6) step();
    settle();
    chk("miss_cnt_1",   CW'(miss_cnt_o),  CW'(16'd1));
    chk("miss_hold_v",  CW'(mmu_cmd_v_o), CW'(1'b0));
    miss_done_i = 1;
    step();
    miss_done_i = 0;
    settle();
    chk("replay1_v",  CW'(mmu_cmd_v_o), CW'(1'b1));
    chk("replay1_va", CW'(mmu_cmd_o[VW-1:0]), CW'(39'h200));
    step();
    mmu_resp_v_i = 1; cache_miss_i = 1;
    step();
    mmu_resp_v_i = 0; cache_miss_i = 0;
    settle();
    chk("miss_cnt_2", CW'(miss_cnt_o), CW'(16'd2));
    step(); step();
    miss_done_i = 1;
    step();
    miss_done_i = 0;
    settle();
    chk("replay2_v",  CW'(mmu_cmd_v_o), CW'(1'b1));
    chk("replay2_va", CW'(mmu_cmd_o[VW-1:0]), CW'(39'h200));
    step();
    mmu_resp_v_i = 1;
    settle();
    chk("replay_hit", CW'(result_v_o), CW'(1'b1));
    step();
    mmu_resp_v_i = 0;
    settle();
    chk("replay_done_busy", CW'(busy_o), CW'(1'b0));

    // Flush while waiting with two queued.
    rst();
    issued_q.delete();
    mmu_cmd_ready_i = 1;
    send(mk_cmd(4'h1, 64'h0, 39'h400), 4);
    send(mk_cmd(4'h1, 64'h0, 39'h408), 4);
    send(mk_cmd(4'h1, 64'h0, 39'h410), 4);
    flush_i = 1;
    settle();
    chk("flush_mv",   CW'(mmu_cmd_v_o), CW'(1'b0));
    chk("flush_busy", CW'(busy_o),      CW'(1'b1));
    step();
    flush_i = 0;
    step(); step();
    mmu_resp_v_i = 1;
    settle();
    chk("drain_result", CW'(result_v_o), CW'(1'b0));
    step();
    mmu_resp_v_i = 0;
    settle();
    chk("drain_busy", CW'(busy_o),      CW'(1'b0));
    chk("drain_mv",   CW'(mmu_cmd_v_o), CW'(1'b0));
    repeat (3) step();
    chk("flush_issue_count", CW'(issued_q.size()), CW'(1));

    // Reset pulse while in the miss state with two queued.
    rst();
    mmu_cmd_ready_i = 1;
    send(mk_cmd(4'h1, 64'h0, 39'h500), 4);
    send(mk_cmd(4'h1, 64'h0, 39'h508), 4);
    send(mk_cmd(4'h1, 64'h0, 39'h510), 4);
    mmu_resp_v_i = 1; cache_miss_i = 1;
    step();
    mmu_resp_v_i = 0; cache_miss_i = 0;
    settle();
    chk("pre_rst_busy", CW'(busy_o), CW'(1'b1));
    reset_n_i = 0;
    step();
    reset_n_i = 1;
    settle();
    chk("post_rst_mv",   CW'(mmu_cmd_v_o), CW'(1'b0));
    chk("post_rst_miss", CW'(miss_cnt_o),  CW'(16'd0));
    chk("post_rst_busy", CW'(busy_o),      CW'(1'b0));
    miss_done_i = 1;
    step();
    miss_done_i = 0;
    mmu_resp_v_i = 1;
    settle();
    chk("late_resp_result", CW'(result_v_o), CW'(1'b0));
    step();
    mmu_resp_v_i = 0;
    settle();
    chk("late_mv",   CW'(mmu_cmd_v_o), CW'(1'b0));
    chk("late_busy", CW'(busy_o),      CW'(1'b0));

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      reset_n_i       = ($urandom_range(0, 299) != 0);
      cmd_v_i         = 1'($urandom_range(0, 1));
      cmd_i           = mk_cmd(4'($urandom), {$urandom, $urandom}, VW'({$urandom, $urandom}));
      mmu_cmd_ready_i = ($urandom_range(0, 3) != 0);
      mmu_resp_v_i    = ($urandom_range(0, 2) == 0);
      cache_miss_i    = 1'($urandom_range(0, 1));
      miss_done_i     = ($urandom_range(0, 4) == 0);
      flush_i         = ($urandom_range(0, 29) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
